// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential radix-2 Booth multiplier.
package mult_pkg;
    localparam int OP_W   = 8;
    localparam int ACC_W  = 9;
    localparam int PROD_W = 17;
    localparam int STEPS  = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/subtract M by {Q[0],q_1},
// then arithmetic shift of {A,Q,q_1} right by one.
module booth_step
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] m,
    input  logic [OP_W-1:0]  q,
    input  logic             q_1,
    output logic [ACC_W-1:0] a_next,
    output logic [OP_W-1:0]  q_next,
    output logic             q_1_next
);
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_next   = {sum[ACC_W-1], sum[ACC_W-1:1]};
        q_next   = {sum[0], q[OP_W-1:1]};
        q_1_next = q[0];
    end
endmodule

// File: rtl/multiply.sv
// Sequential 8x8 signed Booth multiplier: load on start, eight steps, hold in DONE.
module multiply
    import mult_pkg::*;
(
    input  logic              rst,
    input  logic              start,
    output logic [PROD_W-1:0] prod,
    input  logic [OP_W-1:0]   inp1,
    input  logic [OP_W-1:0]   inp2,
    input  logic              clk,
    output logic              rdy
);
    // Handshake: start is a level request sampled only in IDLE; rdy stays high
    // with prod valid until start is seen low, so every new multiply needs start
    // to drop first. prod keeps its last result until the next multiply completes.
    state_t           state;
    logic [ACC_W-1:0] a;
    logic [ACC_W-1:0] m;
    logic [OP_W-1:0]  q;
    logic             q_1;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] a_n;
    logic [OP_W-1:0]  q_n;
    logic             q_1_n;

    booth_step u_step (
        .a        (a),
        .m        (m),
        .q        (q),
        .q_1      (q_1),
        .a_next   (a_n),
        .q_next   (q_n),
        .q_1_next (q_1_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            rdy   <= 1'b0;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        m     <= {inp1[OP_W-1], inp1};
                        q     <= inp2;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a   <= a_n;
                    q   <= q_n;
                    q_1 <= q_1_n;
                    cnt <= cnt + 1'b1;
                    // Capture the product from the final step so it is valid with rdy.
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state <= DONE;
                        rdy   <= 1'b1;
                        prod  <= {a_n, q_n};
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        rdy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiply.sv
// Self-checking bench for multiply: directed and random signed operands against
// an integer-arithmetic reference, plus latency, hold, abort and reset cases.
module tb_multiply;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  inp1;
    logic [7:0]  inp2;
    logic [16:0] prod;
    logic        rdy;

    int checks = 0;
    int errors = 0;

    multiply dut (
        .rst   (rst),
        .start (start),
        .prod  (prod),
        .inp1  (inp1),
        .inp2  (inp2),
        .clk   (clk),
        .rdy   (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = $signed(x) * $signed(y);
        return p[16:0];
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a point between edges; start rises immediately.
    task automatic run_mult(input logic [7:0] x, input logic [7:0] y,
                            input int hold, input bit scramble);
        logic [16:0] exp;
        int edges;
        exp   = ref_prod(x, y);
        inp1  = x;
        inp2  = y;
        start = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (scramble && edges == 1) begin
                inp1 = 8'($urandom);
                inp2 = 8'($urandom);
            end
            if (rdy) break;
        end
        check("latency", 17'(edges), 17'd9);
        check("prod", prod, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", 17'(rdy), 17'd1);
            check("hold_prod", prod, exp);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_drop", 17'(rdy), 17'd0);
        check("prod_keep", prod, exp);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        inp1  = 8'd10;
        inp2  = 8'd11;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 17'(rdy), 17'd0);
        check("reset_prod", prod, 17'd0);

        @(negedge clk);
        rst = 1'b0;
        run_mult(8'd10, 8'd11, 0, 1'b0);
        check("const_110", prod, 17'd110);
        @(negedge clk); run_mult(8'd14, 8'd13, 0, 1'b0);
        @(negedge clk); run_mult(8'd24, 8'd34, 0, 1'b0);
        @(negedge clk); run_mult(8'd76, 8'd98, 0, 1'b0);
        @(negedge clk); run_mult(8'd101, 8'd102, 0, 1'b0);
        check("const_10302", prod, 17'h0283E);
        @(negedge clk); run_mult(8'hFF, 8'd127, 0, 1'b0);
        check("const_m1x127", prod, 17'h1FF81);
        @(negedge clk); run_mult(8'h80, 8'h80, 0, 1'b0);
        check("const_16384", prod, 17'd16384);
        @(negedge clk); run_mult(8'h80, 8'd127, 0, 1'b0);
        check("const_m16256", prod, 17'h1C080);
        @(negedge clk); run_mult(8'd0, 8'hFB, 0, 1'b0);

        // Operands changed mid-operation and start held after completion.
        @(negedge clk); run_mult(8'hC3, 8'h5A, 3, 1'b1);
        @(negedge clk); run_mult(8'h7F, 8'h81, 4, 1'b1);

        // Abort mid-BUSY: reset takes effect without waiting for a clock edge.
        @(negedge clk);
        inp1  = 8'd55;
        inp2  = 8'd77;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_rdy", 17'(rdy), 17'd0);
        check("abort_prod", prod, 17'd0);
        @(negedge clk);
        check("abort_hold_rdy", 17'(rdy), 17'd0);
        // start already high as reset falls: the first free edge samples it.
        rst = 1'b0;
        run_mult(8'hE7, 8'd33, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            run_mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
